// File: rtl/nonce_target_scan.sv
// Scans NUM_NONCES H0 words from shared memory against a difficulty target,
// tracks the first winning nonce and the minimum hash, then writes a 3-word
// result record back to memory.
// Optional feature macro: SCAN_EARLY_EXIT_EN (stop reading at the first winner).
module nonce_target_scan #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NONCE_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        hash_in_addr,
  input  logic [15:0]        result_addr,
  input  logic [31:0]        target,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] first_nonce,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        memory_addr,
  output logic [31:0]        memory_write_data,
  input  logic [31:0]        memory_read_data
);

  localparam int unsigned CNT_W = $clog2(NUM_NONCES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WR0  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [15:0]        r_base, w_base_n;
  logic [15:0]        r_res, w_res_n;
  logic [31:0]        r_target, w_target_n;
  logic               r_found, w_found_n;
  logic [NONCE_W-1:0] r_first, w_first_n;
  logic [31:0]        r_min_hash, w_min_hash_n;
  logic [NONCE_W-1:0] r_min_nonce, w_min_nonce_n;
  logic               r_done, w_done_n;
  logic               r_we, w_we_n;
  logic [15:0]        r_addr, w_addr_n;
  logic [31:0]        r_wdata, w_wdata_n;

  logic               w_capture;
  logic [NONCE_W-1:0] w_cap_idx;
  logic               w_win;
  logic               w_new_win;
  logic               w_lt_min;

  assign mem_clk           = clk;
  assign done              = r_done;
  assign found             = r_found;
  assign first_nonce       = r_first;
  assign mem_we            = r_we;
  assign memory_addr       = r_addr;
  assign memory_write_data = r_wdata;

  // State and datapath registers; reset drops straight back to IDLE with writes off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_res       <= '0;
      r_target    <= '0;
      r_found     <= 1'b0;
      r_first     <= '0;
      r_min_hash  <= 32'hFFFF_FFFF;
      r_min_nonce <= '0;
      r_done      <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_base      <= w_base_n;
      r_res       <= w_res_n;
      r_target    <= w_target_n;
      r_found     <= w_found_n;
      r_first     <= w_first_n;
      r_min_hash  <= w_min_hash_n;
      r_min_nonce <= w_min_nonce_n;
      r_done      <= w_done_n;
      r_we        <= w_we_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
    end
  end

  // Next-state, scan bookkeeping and registered memory-port values.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_base_n      = r_base;
    w_res_n       = r_res;
    w_target_n    = r_target;
    w_found_n     = r_found;
    w_first_n     = r_first;
    w_min_hash_n  = r_min_hash;
    w_min_nonce_n = r_min_nonce;
    w_done_n      = (r_state == IDLE);
    w_we_n        = 1'b0;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;

    // Count value k in READ means word k-1 is on the read-data bus this cycle.
    w_capture = (r_state == READ) && (r_cnt != '0);
    w_cap_idx = NONCE_W'(r_cnt - CNT_W'(1));
    w_win     = (memory_read_data < r_target);
    w_new_win = w_capture && w_win && !r_found;
    w_lt_min  = (memory_read_data < r_min_hash);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_base_n      = hash_in_addr;
          w_res_n       = result_addr;
          w_target_n    = target;
          w_found_n     = 1'b0;
          w_first_n     = '0;
          w_min_hash_n  = 32'hFFFF_FFFF;
          w_min_nonce_n = '0;
          w_addr_n      = hash_in_addr;
          w_cnt_n       = '0;
          w_state_n     = READ;
        end
      end
      READ: begin
        w_cnt_n = r_cnt + CNT_W'(1);
        if (r_cnt < CNT_W'(NUM_NONCES - 1)) begin
          w_addr_n = r_base + 16'(r_cnt) + 16'd1;
        end
        if (w_new_win) begin
          w_found_n = 1'b1;
          w_first_n = w_cap_idx;
        end
        if (w_capture && w_lt_min) begin
          w_min_hash_n  = memory_read_data;
          w_min_nonce_n = w_cap_idx;
        end
        if (r_cnt == CNT_W'(NUM_NONCES)) begin
          w_state_n = WR0;
        end
`ifdef SCAN_EARLY_EXIT_EN
        if (w_new_win) begin
          w_state_n = WR0;
        end
`else
`endif
        if (w_state_n == WR0) begin
          w_we_n    = 1'b1;
          w_addr_n  = r_res;
          w_wdata_n = (32'(w_found_n) << 31) | 32'(w_first_n);
        end
      end
      WR0: begin
        w_we_n    = 1'b1;
        w_addr_n  = r_res + 16'd1;
        w_wdata_n = r_min_hash;
        w_state_n = WR1;
      end
      WR1: begin
        w_we_n    = 1'b1;
        w_addr_n  = r_res + 16'd2;
        w_wdata_n = 32'(r_min_nonce);
        w_state_n = WR2;
      end
      WR2: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nonce_target_scan.sv
// Self-checking bench for nonce_target_scan: memory model, reference scan model,
// directed scenarios and randomized scans.
module tb_nonce_target_scan;

  localparam int N = 16;
`ifdef SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_in_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  first_nonce;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] rd_q;

  always #5 clk = ~clk;

  nonce_target_scan #(.NUM_NONCES(N), .NONCE_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hash_in_addr(hash_in_addr),
    .result_addr(result_addr), .target(target), .done(done), .found(found),
    .first_nonce(first_nonce), .mem_clk(mem_clk), .mem_we(mem_we),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data),
    .memory_read_data(rd_q)
  );

  // Synchronous-read memory plus a per-cycle log of the memory port.
  logic [31:0] mem [0:65535];
  typedef struct packed { logic [15:0] a; logic we; logic [31:0] d; } smp_t;
  smp_t log_q[$];

  always @(posedge mem_clk) begin
    rd_q <= mem[memory_addr];
    log_q.push_back({memory_addr, mem_we, memory_write_data});
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] hv [N];
  // Reference results
  bit          m_found;
  int          m_first;
  logic [31:0] m_min;
  int          m_mn;
  int          m_lat;
  int          m_nscan;
  // Observed results
  int          obs_lat;
  bit          obs_timeout;
  int          obs_nw;
  logic [15:0] obs_wa [3];
  logic [31:0] obs_wd [3];
  logic [15:0] obs_last_rd;

  // Reference: plain walk over the hash list.
  task automatic model(input logic [31:0] tgt);
    m_found = 0; m_first = 0; m_min = 32'hFFFF_FFFF; m_mn = 0; m_nscan = N;
    for (int i = 0; i < N; i++) begin
      if (hv[i] < tgt && !m_found) begin m_found = 1; m_first = i; end
      if (hv[i] < m_min) begin m_min = hv[i]; m_mn = i; end
      if (EARLY && m_found) begin m_nscan = i + 1; break; end
    end
    m_lat = (EARLY && m_found) ? m_first + 6 : N + 5;
  endtask

  // Loads hashes, runs one scan, and extracts observations from the port log.
  task automatic do_scan(input logic [15:0] base, input logic [15:0] res,
                         input logic [31:0] tgt, input int poke);
    int idx0;
    bit seen;
    for (int i = 0; i < N; i++) mem[16'(int'(base) + i)] = hv[i];
    model(tgt);
    hash_in_addr = base; result_addr = res; target = tgt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx0 = log_q.size();
    obs_lat = 0; obs_timeout = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      obs_lat++;
      if (c == poke) begin start = 1'b1; hash_in_addr = ~base; target = '1; end
      else if (c == poke + 1) begin start = 1'b0; hash_in_addr = base; target = tgt; end
      if (done) begin obs_timeout = 0; break; end
    end
    obs_nw = 0; seen = 0; obs_last_rd = '0;
    for (int k = 0; k < 3; k++) begin obs_wa[k] = '0; obs_wd[k] = '0; end
    for (int k = idx0; k < log_q.size(); k++) begin
      if (log_q[k].we) begin
        if (obs_nw < 3) begin obs_wa[obs_nw] = log_q[k].a; obs_wd[obs_nw] = log_q[k].d; end
        obs_nw++; seen = 1;
      end else if (!seen) begin
        obs_last_rd = log_q[k].a;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; hash_in_addr = '0; result_addr = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", done); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (memory_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", memory_addr); end
    checks++; if (memory_write_data !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", memory_write_data); end
    checks++; if (found !== 1'b0 || first_nonce !== 8'h0) begin failures++; $display("FAIL reset_found got=%b/%h exp=0/00", found, first_nonce); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL idle_done got=%b exp=1", done); end
  endtask

  task automatic test_no_win();
    for (int i = 0; i < N; i++) hv[i] = 32'h8000_0000 + i;
    do_scan(16'h0100, 16'h0200, 32'h8000_0000, -1);
    checks++; if (obs_timeout || obs_lat != N + 5) begin failures++; $display("FAIL nowin_latency got=%0d exp=%0d", obs_lat, N + 5); end
    checks++; if (found !== 1'b0) begin failures++; $display("FAIL nowin_found got=%b exp=0", found); end
    checks++; if (obs_wd[0] !== 32'h0 || obs_wd[1] !== 32'h8000_0000 || obs_wd[2] !== 32'h0) begin
      failures++; $display("FAIL nowin_record got=%h %h %h exp=0 80000000 0", obs_wd[0], obs_wd[1], obs_wd[2]); end
    checks++; if (obs_wa[0] !== 16'h0200 || obs_wa[2] !== 16'h0202) begin
      failures++; $display("FAIL nowin_waddr got=%h %h exp=0200 0202", obs_wa[0], obs_wa[2]); end
  endtask

  task automatic test_single_win();
    for (int i = 0; i < N; i++) hv[i] = 32'hFFFF_0000;
    hv[5] = 32'h0000_1234;
    do_scan(16'h1000, 16'h2000, 32'h0001_0000, 3);
    checks++; if (obs_timeout || obs_lat != (EARLY ? 11 : 21)) begin failures++; $display("FAIL win5_latency got=%0d exp=%0d", obs_lat, EARLY ? 11 : 21); end
    checks++; if (found !== 1'b1 || first_nonce !== 8'd5) begin failures++; $display("FAIL win5_found got=%b/%0d exp=1/5", found, first_nonce); end
    checks++; if (obs_nw != 3 || obs_wd[0] !== 32'h8000_0005 || obs_wd[1] !== 32'h0000_1234 || obs_wd[2] !== 32'd5) begin
      failures++; $display("FAIL win5_record got=n%0d %h %h %h exp=n3 80000005 00001234 5", obs_nw, obs_wd[0], obs_wd[1], obs_wd[2]); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < N; i++) hv[i] = 32'h1000_0000 | $urandom;
    hv[3] = 32'h10; hv[9] = 32'h10;
    do_scan(16'h3000, 16'h3100, 32'h20, -1);
    checks++; if (first_nonce !== 8'd3) begin failures++; $display("FAIL tie_first got=%0d exp=3", first_nonce); end
    checks++; if (obs_wd[1] !== 32'h10 || obs_wd[2] !== 32'd3) begin failures++; $display("FAIL tie_min got=%h/%0d exp=10/3", obs_wd[1], obs_wd[2]); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++) hv[i] = $urandom;
    do_scan(16'hFFFA, 16'hFFFF, $urandom, -1);
    checks++; if (obs_wa[0] !== 16'hFFFF || obs_wa[1] !== 16'h0000 || obs_wa[2] !== 16'h0001) begin
      failures++; $display("FAIL wrap_waddr got=%h %h %h exp=ffff 0000 0001", obs_wa[0], obs_wa[1], obs_wa[2]); end
    checks++; if (obs_wd[1] !== m_min || obs_wd[2] !== 32'(m_mn)) begin
      failures++; $display("FAIL wrap_min got=%h/%0d exp=%h/%0d", obs_wd[1], obs_wd[2], m_min, m_mn); end
    checks++; if (obs_last_rd !== 16'(32'hFFFA + ((m_nscan < N) ? m_nscan : N - 1))) begin
      failures++; $display("FAIL wrap_lastrd got=%h", obs_last_rd); end
  endtask

  task automatic test_reset_mid();
    int idx;
    int nwe;
    for (int i = 0; i < N; i++) hv[i] = 32'h4000_0000 + i;
    for (int i = 0; i < N; i++) mem[16'(32'h0500 + i)] = hv[i];
    hash_in_addr = 16'h0500; result_addr = 16'h0600; target = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL midreset_now got=done%b we%b exp=1/0", done, mem_we); end
    idx = log_q.size();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (N + 8) @(posedge clk);
    #1;
    nwe = 0;
    for (int k = idx; k < log_q.size(); k++) if (log_q[k].we) nwe++;
    checks++; if (nwe != 0 || done !== 1'b1) begin failures++; $display("FAIL midreset_nowrites got=%0d done=%b exp=0/1", nwe, done); end
    hv[7] = 32'h0000_0042;
    do_scan(16'h0500, 16'h0600, 32'h0000_1000, -1);
    checks++; if (found !== 1'b1 || first_nonce !== 8'd7 || obs_wd[0] !== 32'h8000_0007 || obs_wd[1] !== 32'h42) begin
      failures++; $display("FAIL midreset_rescan got=%b/%0d %h %h exp=1/7 80000007 42", found, first_nonce, obs_wd[0], obs_wd[1]); end
  endtask

  task automatic test_early_exit();
    for (int i = 0; i < N; i++) hv[i] = 32'hFFFF_FFF0;
    hv[2] = 32'h1;
    do_scan(16'h7000, 16'h7100, 32'h100, 3);
    checks++; if (obs_timeout || obs_lat != (EARLY ? 8 : 21)) begin failures++; $display("FAIL early_latency got=%0d exp=%0d", obs_lat, EARLY ? 8 : 21); end
    checks++; if (obs_last_rd !== (EARLY ? 16'h7003 : 16'h700F)) begin failures++; $display("FAIL early_lastrd got=%h exp=%h", obs_last_rd, EARLY ? 16'h7003 : 16'h700F); end
    checks++; if (obs_wd[0] !== 32'h8000_0002 || obs_wd[1] !== 32'h1 || obs_wd[2] !== 32'd2) begin
      failures++; $display("FAIL early_record got=%h %h %h exp=80000002 1 2", obs_wd[0], obs_wd[1], obs_wd[2]); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic [15:0] base;
    logic [15:0] res;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) hv[i] = $urandom >> $urandom_range(0, 6);
      tgt = $urandom >> $urandom_range(0, 8);
      if (it == 0) tgt = 32'h0;
      if (it == 1) begin tgt = 32'hFFFF_FFFF; hv[0] = 32'hFFFF_FFFF; end
      if (it == 2) hv[N-1] = 32'h0;
      if (it == 3) hv[$urandom_range(1, N-1)] = hv[0];
      base = 16'($urandom); res = 16'($urandom);
      do_scan(base, res, tgt, (it % 2 == 0) ? 4 : -1);
      checks++; if (obs_timeout || obs_lat != m_lat) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, obs_lat, m_lat); end
      checks++; if (found !== m_found || first_nonce !== 8'(m_first)) begin
        failures++; $display("FAIL rnd%0d_found got=%b/%0d exp=%b/%0d", it, found, first_nonce, m_found, m_first); end
      checks++; if (obs_nw != 3 || obs_wa[0] !== res || obs_wa[1] !== 16'(res + 16'd1) || obs_wa[2] !== 16'(res + 16'd2)) begin
        failures++; $display("FAIL rnd%0d_waddr got=n%0d %h %h %h base=%h", it, obs_nw, obs_wa[0], obs_wa[1], obs_wa[2], res); end
      checks++; if (obs_wd[0] !== ((32'(m_found) << 31) | 32'(m_first)) || obs_wd[1] !== m_min || obs_wd[2] !== 32'(m_mn)) begin
        failures++; $display("FAIL rnd%0d_record got=%h %h %h exp=%h %h %0d", it, obs_wd[0], obs_wd[1], obs_wd[2],
                             (32'(m_found) << 31) | 32'(m_first), m_min, m_mn); end
      checks++; if (obs_last_rd !== 16'(int'(base) + ((m_nscan < N) ? m_nscan : N - 1))) begin
        failures++; $display("FAIL rnd%0d_lastrd got=%h base=%h nscan=%0d", it, obs_last_rd, base, m_nscan); end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    test_reset();
    test_no_win();
    test_single_win();
    test_tie();
    test_wrap();
    test_reset_mid();
    test_early_exit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
